// File: rtl/ppg_pkg.sv
// ppg_pkg
// Shared definitions for the PPG sample-FIFO drain path.
//   ppg_rd_state_t : reader state machine encoding (IDLE, RUN, DRAIN)
//   PPG_WIDTH      : default sample width
//   PPG_WINDOW     : default analysis window length in samples
//   PPG_SEQ_W      : default sequence-number width (PPG_RD_SEQ_EN builds only)
//   ppg_credit_ok  : true while another FIFO read can be issued without
//                    overflowing the 2-entry output buffer
package ppg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } ppg_rd_state_t;

    localparam int PPG_WIDTH  = 10;
    localparam int PPG_WINDOW = 64;
    localparam int PPG_SEQ_W  = 16;

    // Every sample already buffered or still on its way from the FIFO holds a
    // buffer slot, so a new read is only safe while fewer than two are claimed.
    function automatic logic ppg_credit_ok(input logic [1:0] occ, input logic inflight);
        return ({1'b0, occ} + {2'b00, inflight}) < 3'd2;
    endfunction

endpackage

// File: rtl/ppg_skid_buf.sv
// ppg_skid_buf
// Two-entry FIFO that absorbs the FIFO's one-cycle read latency.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   push       : write push_data at the tail
//   push_data  : entry to store (W bits)
//   pop        : drop the head entry (caller guarantees occ != 0)
//   occ        : number of stored entries, 0..2
//   head_data  : oldest entry; only meaningful while occ != 0
// The caller guarantees no push when full.
module ppg_skid_buf #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [1:0]   occ,
    output logic [W-1:0] head_data
);

    logic [W-1:0] mem [2];
    logic         rd_ptr;
    logic         wr_ptr;

    // A write only lands on the head slot when the buffer is empty, so the
    // head stays stable from the moment it becomes valid until it is popped.
    assign head_data = mem[rd_ptr];

    // Storage, pointers and occupancy. Push and pop in the same cycle leave
    // the occupancy unchanged while both pointers advance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: rtl/ppg_fifo_reader.sv
// ppg_fifo_reader
// Drain side of the PPG sample FIFO: pops samples from the FIFO's
// registered-read port, buffers them in a 2-entry skid buffer and presents
// them on a valid/ready stream, tagging each with its position in a
// WINDOW-sample analysis window.
// Optional feature macro: PPG_RD_SEQ_EN adds m_seq, a per-sample sequence
// number stamped at capture that travels with its sample.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   enable     : allows new FIFO reads
//   fifo_empty : FIFO empty flag
//   fifo_rd_en : FIFO pop request
//   fifo_data  : FIFO read data, valid the cycle after fifo_rd_en
//   m_valid, m_ready, m_data : output sample stream
//   m_last     : last sample of the current window
//   win_idx    : index of m_data within its window
//   busy       : a read is in flight or the buffer holds samples
//   m_seq      : sample sequence number (PPG_RD_SEQ_EN only)
module ppg_fifo_reader import ppg_pkg::*; #(
    parameter int WIDTH  = PPG_WIDTH,
    parameter int WINDOW = PPG_WINDOW,
    parameter int SEQ_W  = PPG_SEQ_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       fifo_empty,
    output logic                       fifo_rd_en,
    input  logic [WIDTH-1:0]           fifo_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [WIDTH-1:0]           m_data,
    output logic                       m_last,
    output logic [$clog2(WINDOW)-1:0]  win_idx,
    output logic                       busy
`ifdef PPG_RD_SEQ_EN
    ,
    output logic [SEQ_W-1:0]           m_seq
`endif
);

    localparam int IDX_W = $clog2(WINDOW);

    // Reject parameter sets the window counter and sequence tag cannot handle.
    if (WINDOW < 2 || SEQ_W < 1) begin : g_bad_params
        $error("ppg_fifo_reader: WINDOW must be >= 2 and SEQ_W >= 1");
    end

`ifdef PPG_RD_SEQ_EN
    localparam int BUF_W = WIDTH + SEQ_W;
`else
    localparam int BUF_W = WIDTH;
`endif

    ppg_rd_state_t    state;
    ppg_rd_state_t    state_next;
    logic             inflight;
    logic [1:0]       occ;
    logic             pop;
    logic [BUF_W-1:0] push_data;
    logic [BUF_W-1:0] head_data;

`ifdef PPG_RD_SEQ_EN
    logic [SEQ_W-1:0] seq_cnt;

    // Sequence numbers are stamped at capture so they stay attached to their
    // sample through the buffer; the counter wraps naturally at 2^SEQ_W.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seq_cnt <= '0;
        end else if (inflight) begin
            seq_cnt <= seq_cnt + 1'b1;
        end
    end

    assign push_data = {seq_cnt, fifo_data};
    assign m_seq     = head_data[BUF_W-1:WIDTH];
`else
    assign push_data = fifo_data;
`endif

    assign m_valid = (occ != 2'd0);
    assign m_data  = head_data[WIDTH-1:0];
    assign pop     = m_valid & m_ready;
    assign busy    = inflight | m_valid;
    assign m_last  = m_valid & (win_idx == IDX_W'(WINDOW - 1));

    ppg_skid_buf #(
        .W(BUF_W)
    ) u_buf (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight),
        .push_data (push_data),
        .pop       (pop),
        .occ       (occ),
        .head_data (head_data)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and read request. The credit check deliberately ignores a
    // same-cycle pop so that fifo_rd_en depends only on registered state and
    // fifo_empty, never combinationally on m_ready. DRAIN keeps the block
    // alive until a sample fetched before enable dropped has been delivered.
    always_comb begin
        state_next = state;
        fifo_rd_en = 1'b0;
        case (state)
            IDLE: begin
                if (enable) state_next = RUN;
            end
            RUN: begin
                fifo_rd_en = ~fifo_empty & ppg_credit_ok(occ, inflight);
                if (!enable) state_next = DRAIN;
            end
            DRAIN: begin
                if (enable) begin
                    state_next = RUN;
                end else if (!inflight && occ == 2'd0) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A read issued this cycle returns data next cycle; this flag marks the
    // cycle in which fifo_data must be captured into the buffer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inflight <= 1'b0;
        end else begin
            inflight <= fifo_rd_en;
        end
    end

    // Window position of the head sample; advances only when it is consumed,
    // so it stays stable while the sample waits on backpressure.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_idx <= '0;
        end else if (pop) begin
            if (win_idx == IDX_W'(WINDOW - 1)) begin
                win_idx <= '0;
            end else begin
                win_idx <= win_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ppg_fifo_reader.sv
// tb_ppg_fifo_reader
// Self-checking bench for ppg_fifo_reader with WINDOW=4 and SEQ_W=2.
// A registered-read FIFO model feeds the DUT; a queue-based reference model
// predicts every output each cycle, and directed scenarios add literal
// expectations on the recorded stream.
// Optional feature macro: PPG_RD_SEQ_EN (connects and checks m_seq).
module tb_ppg_fifo_reader;

    localparam int WIDTH  = 10;
    localparam int WINDOW = 4;
    localparam int SEQ_W  = 2;
    localparam int IDX_W  = $clog2(WINDOW);

    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_DRAIN = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              enable = 1'b0;
    logic              m_ready = 1'b0;
    logic              fifo_empty = 1'b1;
    logic [WIDTH-1:0]  fifo_data = '0;
    logic              fifo_rd_en;
    logic              m_valid;
    logic [WIDTH-1:0]  m_data;
    logic              m_last;
    logic [IDX_W-1:0]  win_idx;
    logic              busy;
`ifdef PPG_RD_SEQ_EN
    logic [SEQ_W-1:0]  m_seq;
`endif

    logic              push_req = 1'b0;
    logic [WIDTH-1:0]  push_val = '0;

    int fifo_q[$];
    int sent_q[$];

    int checks = 0;
    int errors = 0;

    // Reference model state, advanced at each rising edge.
    int mst = S_IDLE;
    int mbuf_d[$];
    int mbuf_s[$];
    bit minfl = 1'b0;
    int minfl_d = 0;
    int mwin = 0;
    int mseq = 0;
    int rd_ptr = 0;

    // Decisions the compare process makes for the coming edge.
    bit p_pop = 1'b0;
    bit p_rd = 1'b0;
    int p_next = S_IDLE;

    // Recorders used by the directed scenarios.
    int cyc = 0;
    int rd_count = 0;
    int first_rd = -1;
    int first_val = -1;
    int rx_d[$];
    int rx_i[$];
    int rx_l[$];
    int rx_s[$];

    ppg_fifo_reader #(
        .WIDTH  (WIDTH),
        .WINDOW (WINDOW),
        .SEQ_W  (SEQ_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_data  (fifo_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .win_idx    (win_idx),
        .busy       (busy)
`ifdef PPG_RD_SEQ_EN
        ,
        .m_seq      (m_seq)
`endif
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Upstream FIFO with a registered read port. It is never reset, just like
    // the real FIFO; sent_q keeps every sample ever written, in order.
    always @(posedge clk) begin
        if (fifo_rd_en && fifo_q.size() > 0) begin
            fifo_data <= WIDTH'(fifo_q.pop_front());
        end
        if (push_req) begin
            fifo_q.push_back(int'(push_val));
            sent_q.push_back(int'(push_val));
        end
        fifo_empty <= (fifo_q.size() == 0);
    end

    // Reference model update: apply the pop, capture and read decided in the
    // preceding half cycle; reset discards buffered and in-flight samples but
    // leaves the FIFO read pointer where it is.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mst = S_IDLE;
            mbuf_d.delete();
            mbuf_s.delete();
            minfl = 1'b0;
            mwin = 0;
            mseq = 0;
        end else begin
            if (p_pop && mbuf_d.size() > 0) begin
                void'(mbuf_d.pop_front());
                void'(mbuf_s.pop_front());
                mwin = (mwin + 1) % WINDOW;
            end
            if (minfl) begin
                mbuf_d.push_back(minfl_d);
                mbuf_s.push_back(mseq);
                mseq = (mseq + 1) % (1 << SEQ_W);
            end
            if (p_rd) begin
                minfl_d = (rd_ptr < sent_q.size()) ? sent_q[rd_ptr] : -1;
                rd_ptr++;
            end
            minfl = p_rd;
            mst = p_next;
        end
    end

    // One comparison: count it and report a mismatch.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Compare every DUT output against the model, record the stream for the
    // directed scenarios and decide what the model does at the next edge.
    task automatic compareModel();
        bit e_rd;
        bit e_valid;
        e_rd    = (mst == S_RUN) && !fifo_empty && (mbuf_d.size() + int'(minfl) < 2);
        e_valid = (mbuf_d.size() != 0);
        checkOutput("fifo_rd_en", {31'd0, fifo_rd_en}, {31'd0, e_rd});
        checkOutput("m_valid", {31'd0, m_valid}, {31'd0, e_valid});
        checkOutput("busy", {31'd0, busy}, {31'd0, (minfl || e_valid)});
        checkOutput("win_idx", 32'(win_idx), 32'(mwin));
        checkOutput("m_last", {31'd0, m_last}, {31'd0, (e_valid && mwin == WINDOW - 1)});
        if (e_valid) begin
            checkOutput("m_data", 32'(m_data), 32'(mbuf_d[0]));
`ifdef PPG_RD_SEQ_EN
            checkOutput("m_seq", 32'(m_seq), 32'(mbuf_s[0]));
`endif
        end
        if (fifo_rd_en) begin
            rd_count++;
            if (first_rd < 0) first_rd = cyc;
        end
        if (m_valid && first_val < 0) first_val = cyc;
        if (m_valid && m_ready) begin
            rx_d.push_back(int'(m_data));
            rx_i.push_back(int'(win_idx));
            rx_l.push_back(int'(m_last));
`ifdef PPG_RD_SEQ_EN
            rx_s.push_back(int'(m_seq));
`endif
        end
        cyc++;
        p_pop = e_valid && m_ready;
        p_rd  = e_rd;
        case (mst)
            S_IDLE:  p_next = enable ? S_RUN : S_IDLE;
            S_RUN:   p_next = enable ? S_RUN : S_DRAIN;
            default: p_next = enable ? S_RUN : ((!minfl && !e_valid) ? S_IDLE : S_DRAIN);
        endcase
    endtask

    // One clock cycle: check mid-cycle, then return just after the next edge
    // so the caller can drive fresh inputs.
    task automatic stepCycle();
        @(negedge clk);
        compareModel();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of inputs and advance.
    task automatic applyStimulus(input logic en, input logic rdy, input logic push, input int val);
        enable   = en;
        m_ready  = rdy;
        push_req = push;
        push_val = WIDTH'(val);
        stepCycle();
        push_req = 1'b0;
    endtask

    task automatic clearRecord();
        rd_count = 0;
        first_rd = -1;
        first_val = -1;
        cyc = 0;
        rx_d.delete();
        rx_i.delete();
        rx_l.delete();
        rx_s.delete();
    endtask

    task automatic doReset();
        enable = 1'b0;
        push_req = 1'b0;
        reset = 1'b1;
        stepCycle();
        stepCycle();
        reset = 1'b0;
        stepCycle();
    endtask

    // Write n consecutive samples starting at base while the reader is idle.
    task automatic loadFifo(input int base, input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, 1'b1, base + i);
        applyStimulus(1'b0, 1'b1, 1'b0, 0);
    endtask

    initial begin
        int guard;

        // Reset values.
        stepCycle();
        stepCycle();
        checkOutput("rst_m_valid", {31'd0, m_valid}, 32'd0);
        checkOutput("rst_m_data", 32'(m_data), 32'd0);
        checkOutput("rst_m_last", {31'd0, m_last}, 32'd0);
        checkOutput("rst_win_idx", 32'(win_idx), 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        reset = 1'b0;
        stepCycle();

        // Basic drain of five samples.
        $display("[TB] basic drain");
        loadFifo(32'h001, 5);
        clearRecord();
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b1, 1'b0, 0);
        checkOutput("basic_latency", 32'(first_val - first_rd), 32'd2);
        checkOutput("basic_count", 32'(rx_d.size()), 32'd5);
        for (int i = 0; i < rx_d.size() && i < 5; i++)
            checkOutput("basic_data", 32'(rx_d[i]), 32'(i + 1));
        checkOutput("basic_end_valid", {31'd0, m_valid}, 32'd0);
        checkOutput("basic_end_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 0);

        // Window wrap over nine samples.
        $display("[TB] window wrap");
        doReset();
        loadFifo(32'h020, 9);
        clearRecord();
        for (int i = 0; i < 30; i++) applyStimulus(1'b1, 1'b1, 1'b0, 0);
        checkOutput("win_count", 32'(rx_d.size()), 32'd9);
        for (int i = 0; i < rx_d.size() && i < 9; i++) begin
            checkOutput("win_seq_idx", 32'(rx_i[i]), 32'(i % 4));
            checkOutput("win_seq_last", 32'(rx_l[i]), 32'((i % 4) == 3));
            checkOutput("win_seq_data", 32'(rx_d[i]), 32'(32'h020 + i));
        end

        // Backpressure: only two samples fetched while m_ready is low.
        $display("[TB] backpressure");
        doReset();
        loadFifo(32'h101, 10);
        clearRecord();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 0);
            if (i >= 3) checkOutput("bp_hold_data", 32'(m_data), 32'h101);
        end
        checkOutput("bp_reads", 32'(rd_count), 32'd2);
        checkOutput("bp_valid", {31'd0, m_valid}, 32'd1);
        for (int i = 0; i < 30; i++) applyStimulus(1'b1, 1'b1, 1'b0, 0);
        checkOutput("bp_count", 32'(rx_d.size()), 32'd10);
        for (int i = 0; i < rx_d.size() && i < 10; i++)
            checkOutput("bp_data", 32'(rx_d[i]), 32'(32'h101 + i));

        // Asynchronous reset with a full buffer and win_idx away from zero.
        $display("[TB] async reset");
        doReset();
        loadFifo(32'h030, 5);
        clearRecord();
        guard = 0;
        while (rx_d.size() < 1 && guard < 20) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 0);
            guard++;
        end
        checkOutput("ar_first_pop_bound", 32'(rx_d.size()), 32'd1);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 1'b0, 0);
        checkOutput("ar_pre_valid", {31'd0, m_valid}, 32'd1);
        checkOutput("ar_pre_idx", 32'(win_idx), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("ar_valid", {31'd0, m_valid}, 32'd0);
        checkOutput("ar_busy", {31'd0, busy}, 32'd0);
        checkOutput("ar_idx", 32'(win_idx), 32'd0);
        checkOutput("ar_data", 32'(m_data), 32'd0);
        checkOutput("ar_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        stepCycle();
        reset = 1'b0;
        clearRecord();
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b1, 1'b0, 0);
        checkOutput("ar_restart_count", 32'(rx_d.size()), 32'd2);
        if (rx_d.size() > 0) begin
            checkOutput("ar_restart_data", 32'(rx_d[0]), 32'h033);
            checkOutput("ar_restart_idx", 32'(rx_i[0]), 32'd0);
        end

`ifdef PPG_RD_SEQ_EN
        // Sequence numbers restart at reset and wrap at 2^SEQ_W.
        $display("[TB] sequence numbers");
        doReset();
        loadFifo(32'h050, 5);
        clearRecord();
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b1, 1'b0, 0);
        checkOutput("seq_count", 32'(rx_s.size()), 32'd5);
        for (int i = 0; i < rx_s.size() && i < 5; i++)
            checkOutput("seq_value", 32'(rx_s[i]), 32'(i % 4));
`endif

        // Dropping enable in the cycle of the first read still delivers it.
        $display("[TB] disable mid-read");
        doReset();
        loadFifo(32'h040, 3);
        clearRecord();
        applyStimulus(1'b1, 1'b1, 1'b0, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 0);
        checkOutput("dis_read_issued", 32'(rd_count), 32'd1);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 1'b0, 0);
        checkOutput("dis_reads", 32'(rd_count), 32'd1);
        checkOutput("dis_count", 32'(rx_d.size()), 32'd1);
        if (rx_d.size() > 0) checkOutput("dis_data", 32'(rx_d[0]), 32'h040);
        checkOutput("dis_busy", {31'd0, busy}, 32'd0);

        // Random traffic with occasional resets, checked by the model.
        $display("[TB] random traffic");
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                reset = 1'b1;
                stepCycle();
                reset = 1'b0;
            end
            applyStimulus(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6),
                          (fifo_q.size() < 6) && ($urandom_range(0, 1) == 1),
                          int'($urandom_range(0, (1 << WIDTH) - 1)));
        end

        // Drain whatever is left, within a bounded number of cycles.
        guard = 0;
        while ((fifo_q.size() != 0 || busy) && guard < 200) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 0);
            guard++;
        end
        checkOutput("final_drain_done", {31'd0, (fifo_q.size() == 0 && !busy)}, 32'd1);
        checkOutput("final_reads_all", 32'(rd_ptr), 32'(sent_q.size()));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
